// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file: multi-port register file with write forwarding, busy scoreboard and reset sweep
module scoreboard_register_file #(
  parameter int WORD_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              ready,
  input  logic [WRITE_PORTS-1:0]            wr_en,
  input  logic [WRITE_PORTS*IDX_W-1:0]      wr_idx,
  input  logic [WRITE_PORTS*WORD_WIDTH-1:0] wr_data,
  input  logic [READ_PORTS*IDX_W-1:0]       rd_idx,
  output logic [READ_PORTS*WORD_WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]             rd_pending,
  input  logic                              issue_en,
  input  logic [IDX_W-1:0]                  issue_idx,
  output logic [NUM_REGS-1:0]               busy_vec
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [WORD_WIDTH-1:0] regs_q [NUM_REGS];
  logic [WORD_WIDTH-1:0] regs_d [NUM_REGS];
  logic [WRITE_PORTS-1:0] wv;
  logic [READ_PORTS-1:0] rv, hit;
  logic run;
  function automatic logic valid_idx(input logic [IDX_W-1:0] i);
    return (i != '0) && (32'(i) < NUM_REGS);
  endfunction
  assign run      = state_q == RUN;
  assign ready    = run;
  assign busy_vec = busy_q;
  // qualify write and read ports: only nonzero in-range indices while running
  always_comb begin
    wv = '0;
    rv = '0;
    for (int k = 0; k < WRITE_PORTS; k++)
      wv[k] = run & wr_en[k] & valid_idx(wr_idx[k*IDX_W +: IDX_W]);
    for (int p = 0; p < READ_PORTS; p++)
      rv[p] = run & valid_idx(rd_idx[p*IDX_W +: IDX_W]);
  end
  // next state: sweep clear, prioritised writes, scoreboard clear then issue set
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    regs_d    = regs_q;
    if (!run) begin
      regs_d[clr_cnt_q] = '0;
      clr_cnt_d = clr_cnt_q + IDX_W'(1);
      state_d = (32'(clr_cnt_q) == NUM_REGS - 1) ? RUN : CLEAR;
    end
    for (int k = 0; k < WRITE_PORTS; k++)
      if (wv[k]) begin
        regs_d[wr_idx[k*IDX_W +: IDX_W]] = wr_data[k*WORD_WIDTH +: WORD_WIDTH];
        busy_d[wr_idx[k*IDX_W +: IDX_W]] = 1'b0;
      end
    if (run && issue_en && valid_idx(issue_idx))
      busy_d[issue_idx] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end
  // register update; reset restarts the sweep and drops all writes that cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= IDX_W'(1);
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      regs_q    <= regs_d;
    end
  end
  // combinational reads with same-cycle forwarding from the highest matching write port
  always_comb begin
    hit        = '0;
    rd_data    = '0;
    rd_pending = '0;
    for (int p = 0; p < READ_PORTS; p++)
      if (rv[p]) begin
        rd_data[p*WORD_WIDTH +: WORD_WIDTH] = regs_q[rd_idx[p*IDX_W +: IDX_W]];
        for (int k = 0; k < WRITE_PORTS; k++)
          if (wv[k] && wr_idx[k*IDX_W +: IDX_W] == rd_idx[p*IDX_W +: IDX_W]) begin
            hit[p] = 1'b1;
            rd_data[p*WORD_WIDTH +: WORD_WIDTH] = wr_data[k*WORD_WIDTH +: WORD_WIDTH];
          end
        rd_pending[p] = busy_q[rd_idx[p*IDX_W +: IDX_W]] & ~hit[p];
      end
  end
endmodule

// File: tb/tb_scoreboard_register_file.sv
// tb_scoreboard_register_file: directed scoreboard bench for the register file
module tb_scoreboard_register_file;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_idx = '0;
  logic [63:0] wr_data = '0;
  logic [9:0]  rd_idx = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_idx = '0;
  logic [31:0] busy_vec;
  int checks = 0;
  int failures = 0;
  int n;
  typedef struct {int p; logic [31:0] d; logic pd;} exp_t;
  exp_t exp_q[$];

  scoreboard_register_file dut (
    .clk(clk), .reset(reset), .ready(ready),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_pending(rd_pending),
    .issue_en(issue_en), .issue_idx(issue_idx), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic want(input int p, input logic [31:0] d, input logic pd);
    exp_t e;
    e.p = p; e.d = d; e.pd = pd;
    exp_q.push_back(e);
  endtask

  task automatic chk_rd(input string tag);
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_data%0d", tag, e.p), 64'(rd_data[e.p*32 +: 32]), 64'(e.d));
      chk($sformatf("%s_pend%0d", tag, e.p), 64'(rd_pending[e.p]), 64'(e.pd));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 100) begin
      step();
      cnt++;
      if (cnt == 20) begin
        wr_en = '0;
        issue_en = 1'b0;
      end
    end
  endtask

  initial begin
    rd_idx = {5'd0, 5'd5};
    step();
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_busy", 64'(busy_vec), 64'(0));
    want(0, 32'h0, 1'b0);
    chk_rd("rst_rd");
    reset = 1'b0;
    wait_ready(n);
    chk("sweep1_len", 64'(n), 64'(31));
    // 1: write r5 with an issue pending, then reset clears both
    wr_en = 2'b01; wr_idx = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEAD};
    issue_en = 1'b1; issue_idx = 5'd5;
    step();
    wr_en = '0; issue_en = 1'b0;
    want(0, 32'hDEAD, 1'b1);
    chk_rd("t1_pre");
    chk("t1_busy_pre", 64'(busy_vec), 64'(32'h20));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t1_ready_lo", 64'(ready), 64'(0));
    chk("t1_busy_rst", 64'(busy_vec), 64'(0));
    wait_ready(n);
    chk("t1_sweep_len", 64'(n), 64'(31));
    want(0, 32'h0, 1'b0);
    chk_rd("t1_r5");
    chk("t1_busy", 64'(busy_vec), 64'(0));
    // 2: reset mid-sweep restarts the counter; writes/issues during CLEAR are ignored
    wr_en = 2'b01; wr_idx = {5'd0, 5'd4}; wr_data = {32'h0, 32'h99};
    step();
    wr_en = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (9) step();
    chk("t2_mid_ready", 64'(ready), 64'(0));
    reset = 1'b1;
    step();
    reset = 1'b0;
    wr_en = 2'b01; wr_idx = {5'd0, 5'd4}; wr_data = {32'h0, 32'h55};
    issue_en = 1'b1; issue_idx = 5'd4;
    rd_idx = {5'd4, 5'd4};
    want(0, 32'h0, 1'b0);
    want(1, 32'h0, 1'b0);
    chk_rd("t2_clear_rd");
    wait_ready(n);
    chk("t2_sweep_len", 64'(n), 64'(31));
    want(0, 32'h0, 1'b0);
    chk_rd("t2_r4");
    chk("t2_busy", 64'(busy_vec), 64'(0));
    // 3: same-cycle forwarding, then registered value
    rd_idx = {5'd0, 5'd3};
    want(0, 32'h0, 1'b0);
    chk_rd("t3_pre");
    wr_en = 2'b01; wr_idx = {5'd0, 5'd3}; wr_data = {32'h0, 32'h1234};
    want(0, 32'h1234, 1'b0);
    chk_rd("t3_fwd");
    step();
    wr_en = '0;
    want(0, 32'h1234, 1'b0);
    chk_rd("t3_hold");
    // 4: port priority and r0 hard-wired
    wr_en = 2'b11; wr_idx = {5'd7, 5'd7}; wr_data = {32'hB, 32'hA};
    rd_idx = {5'd7, 5'd7};
    want(0, 32'hB, 1'b0);
    want(1, 32'hB, 1'b0);
    chk_rd("t4_fwd");
    step();
    wr_en = 2'b11; wr_idx = {5'd11, 5'd10}; wr_data = {32'h11, 32'h10};
    want(0, 32'hB, 1'b0);
    chk_rd("t4_r7");
    step();
    wr_en = 2'b01; wr_idx = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFF};
    rd_idx = {5'd11, 5'd0};
    want(0, 32'h0, 1'b0);
    want(1, 32'h11, 1'b0);
    chk_rd("t4_r0_fwd");
    step();
    wr_en = '0;
    rd_idx = {5'd10, 5'd0};
    want(0, 32'h0, 1'b0);
    want(1, 32'h10, 1'b0);
    chk_rd("t4_r0");
    // 5: scoreboard issue, resolve, and issue-wins collision
    issue_en = 1'b1; issue_idx = 5'd9;
    step();
    issue_en = 1'b0;
    chk("t5_busy_set", 64'(busy_vec), 64'(32'h200));
    rd_idx = {5'd9, 5'd9};
    want(0, 32'h0, 1'b1);
    want(1, 32'h0, 1'b1);
    chk_rd("t5_pend");
    wr_en = 2'b10; wr_idx = {5'd9, 5'd0}; wr_data = {32'h77, 32'h0};
    want(0, 32'h77, 1'b0);
    chk_rd("t5_fwd");
    step();
    wr_en = '0;
    chk("t5_busy_clr", 64'(busy_vec), 64'(0));
    want(0, 32'h77, 1'b0);
    chk_rd("t5_after");
    issue_en = 1'b1; issue_idx = 5'd9;
    wr_en = 2'b01; wr_idx = {5'd0, 5'd9}; wr_data = {32'h0, 32'h88};
    step();
    wr_en = '0;
    issue_idx = 5'd0;
    step();
    issue_en = 1'b0;
    chk("t5_issue_wins", 64'(busy_vec), 64'(32'h200));
    want(0, 32'h88, 1'b1);
    chk_rd("t5_collide");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
